// File: rtl/vga_scanout_dma.sv
// Framebuffer scanout engine: on each frame-sync it reads one frame of 16-bit pixels
// through a pipelined memory read port and streams them out via a small first-word-fall-through FIFO.
module vga_scanout_dma #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FRAME_PIXELS = 307200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic [ADDR_WIDTH-1:0] i_Back_Buffer_Address,
  input  logic                  i_Swap_Request,
  output logic                  o_Swap_Pending,
  output logic [ADDR_WIDTH-1:0] o_Front_Buffer_Address,
  input  logic                  i_mm2s_fsync,
  output logic                  o_Mem_Read_Valid,
  input  logic                  i_Mem_Read_Ready,
  output logic [ADDR_WIDTH-1:0] o_Mem_Read_Address,
  input  logic                  i_Mem_Data_Valid,
  input  logic [15:0]           i_Mem_Data,
  output logic [15:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  o_Frame_Done,
  output logic                  o_Underflow
);

  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_FSYNC = 2'd1;
  localparam logic [1:0] S_FETCH      = 2'd2;
  localparam logic [1:0] S_DRAIN      = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] front_addr;
  logic [ADDR_WIDTH-1:0] swap_addr;
  logic                  swap_pending;
  logic [CW-1:0]         issued;
  logic [CW-1:0]         accepted;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         discard;
  logic [OW-1:0]         fifo_count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [15:0]           fifo_mem [FIFO_DEPTH];
  logic                  frame_done_q;
  logic                  underflow_q;

  logic          in_frame;
  logic          frame_start;
  logic          rd_fire;
  logic          push;
  logic          drop;
  logic          pop;
  logic          last_pop;
  logic [OW:0]   credit_used;
  logic [OW-1:0] out_after;
  logic [OW-1:0] disc_after;

  assign in_frame    = (state == S_FETCH) || (state == S_DRAIN);
  assign frame_start = i_Enable && i_mm2s_fsync && (state != S_IDLE);

  // Requests in flight are charged against FIFO space up front, so a response always has room.
  assign credit_used        = {1'b0, fifo_count} + {1'b0, outstanding};
  assign o_Mem_Read_Valid   = (state == S_FETCH) && (issued < CW'(FRAME_PIXELS)) &&
                              (credit_used < (OW+1)'(FIFO_DEPTH));
  assign o_Mem_Read_Address = front_addr + (ADDR_WIDTH'(issued) << 1);
  assign rd_fire            = o_Mem_Read_Valid && i_Mem_Read_Ready;

  // Responses to requests from an aborted frame arrive first (in order) and are dropped.
  assign drop       = i_Mem_Data_Valid && (discard != '0);
  assign push       = i_Mem_Data_Valid && (discard == '0) && (outstanding != '0);
  assign out_after  = outstanding + OW'(rd_fire) - OW'(push);
  assign disc_after = discard - OW'(drop);

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : 16'h0000;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign last_pop      = pop && (accepted == CW'(FRAME_PIXELS - 1));

  assign o_Swap_Pending         = swap_pending;
  assign o_Front_Buffer_Address = front_addr;
  assign o_Frame_Done           = frame_done_q;
  assign o_Underflow            = underflow_q;

  // NOTE: the pixel storage has no reset; the read side is gated by fifo_count, so its contents never leak.
  always_ff @(posedge i_Clock) begin
    if (push) fifo_mem[wr_ptr] <= i_Mem_Data;
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= S_IDLE;
      front_addr   <= '0;
      swap_addr    <= '0;
      swap_pending <= 1'b0;
      issued       <= '0;
      accepted     <= '0;
      outstanding  <= '0;
      discard      <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;

      // A request coinciding with a frame start wins, so it is held for the following frame.
      if (i_Swap_Request) begin
        swap_addr    <= i_Back_Buffer_Address;
        swap_pending <= 1'b1;
      end else if (frame_start) begin
        swap_pending <= 1'b0;
      end

      if (!i_Enable || frame_start) begin
        state       <= i_Enable ? S_FETCH : S_IDLE;
        if (frame_start && swap_pending) front_addr <= swap_addr;
        issued      <= '0;
        accepted    <= '0;
        outstanding <= '0;
        discard     <= disc_after + out_after;
        fifo_count  <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        outstanding <= out_after;
        discard     <= disc_after;
        fifo_count  <= fifo_count + OW'(push) - OW'(pop);
        if (rd_fire) issued <= issued + 1'b1;
        if (push)    wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          accepted <= accepted + 1'b1;
        end
        frame_done_q <= last_pop;
        underflow_q  <= m_axis_tready && !m_axis_tvalid && in_frame &&
                        (accepted < CW'(FRAME_PIXELS));
        case (state)
          S_IDLE:  state <= S_WAIT_FSYNC;
          S_FETCH: if (rd_fire && (issued == CW'(FRAME_PIXELS - 1))) state <= S_DRAIN;
          S_DRAIN: if (last_pop) state <= S_WAIT_FSYNC;
          default: ;
        endcase
      end
    end
  end

endmodule
